// File: rtl/cpu_pkg.sv
// Shared core types: pipeline controller states, trap kinds and default datapath widths.
package cpu_pkg;

  localparam int CFG_CPU_WIDTH = 64;
  localparam int CFG_REG_ADDRW = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_WAIT   = 2'd1,
    TRAP_WAIT = 2'd2
  } pipe_ctrl_state_e;

  typedef enum logic [1:0] {
    TRAP_NONE   = 2'd0,
    TRAP_EXCEPT = 2'd1,
    TRAP_MRET   = 2'd2,
    TRAP_INT    = 2'd3
  } trap_kind_e;

  // An exception outranks an mret raised alongside it; mret still selects mepc over an interrupt.
  function automatic trap_kind_e trap_kind(input logic mem_valid, input logic except_en,
                                           input logic mtime_int, input logic mret);
    if (!mem_valid)     return TRAP_NONE;
    else if (except_en) return TRAP_EXCEPT;
    else if (mret)      return TRAP_MRET;
    else if (mtime_int) return TRAP_INT;
    else                return TRAP_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use comparator between the ID sources and a load in EX; purely combinational.
module hazard_det #(
  parameter int REG_ADDRW = 5
) (
  input  logic                 id_valid,
  input  logic [REG_ADDRW-1:0] id_rs1,
  input  logic [REG_ADDRW-1:0] id_rs2,
  input  logic                 id_rs1_ren,
  input  logic                 id_rs2_ren,
  input  logic                 ex_valid,
  input  logic                 ex_lden,
  input  logic [REG_ADDRW-1:0] ex_rdid,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_ren && (id_rs1 == ex_rdid);
  assign rs2_hit  = id_rs2_ren && (id_rs2 == ex_rdid);
  // x0 is never really written, so a load targeting it cannot create a dependency.
  assign load_use = id_valid && ex_valid && ex_lden && (ex_rdid != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline flush/hold sequencing and PC redirect arbitration; redirects are immediate when the
// fetch unit is idle, otherwise latched and replayed on the first idle cycle of a wait state.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int CPU_WIDTH = CFG_CPU_WIDTH,
  parameter int REG_ADDRW = CFG_REG_ADDRW
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic [REG_ADDRW-1:0] i_id_rs1,
  input  logic [REG_ADDRW-1:0] i_id_rs2,
  input  logic                 i_id_rs1_ren,
  input  logic                 i_id_rs2_ren,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_lden,
  input  logic [REG_ADDRW-1:0] i_ex_rdid,
  input  logic                 i_ex_br_en,
  input  logic [CPU_WIDTH-1:0] i_ex_br_pc,
  input  logic                 i_mem_valid,
  input  logic                 i_mem_except_en,
  input  logic                 i_mem_mtime_int,
  input  logic                 i_mem_mret,
  input  logic [CPU_WIDTH-1:0] i_trap_pc,
  input  logic [CPU_WIDTH-1:0] i_mepc,
  input  logic                 i_ifu_busy,
  output logic                 o_flush_ifid,
  output logic                 o_flush_idex,
  output logic                 o_flush_exls,
  output logic                 o_id_hold,
  output logic                 o_fetch_hold,
  output logic                 o_pc_wen,
  output logic [CPU_WIDTH-1:0] o_pc_npc
);

  pipe_ctrl_state_e     state;
  pipe_ctrl_state_e     next_state;
  logic [CPU_WIDTH-1:0] r_tgt;
  logic [CPU_WIDTH-1:0] next_tgt;
  trap_kind_e           kind;
  logic                 trap;
  logic                 br;
  logic                 load_use;
  logic [CPU_WIDTH-1:0] trap_tgt;

  hazard_det #(.REG_ADDRW(REG_ADDRW)) u_hazard_det (
    .id_valid   (i_id_valid),
    .id_rs1     (i_id_rs1),
    .id_rs2     (i_id_rs2),
    .id_rs1_ren (i_id_rs1_ren),
    .id_rs2_ren (i_id_rs2_ren),
    .ex_valid   (i_ex_valid),
    .ex_lden    (i_ex_lden),
    .ex_rdid    (i_ex_rdid),
    .load_use   (load_use)
  );

  assign kind     = trap_kind(i_mem_valid, i_mem_except_en, i_mem_mtime_int, i_mem_mret);
  assign trap     = (kind != TRAP_NONE);
  assign trap_tgt = (kind == TRAP_MRET) ? i_mepc : i_trap_pc;
  assign br       = i_ex_valid && i_ex_br_en;

  always_comb begin
    next_state   = state;
    next_tgt     = r_tgt;
    o_flush_ifid = 1'b0;
    o_flush_idex = 1'b0;
    o_flush_exls = 1'b0;
    o_id_hold    = 1'b0;
    o_fetch_hold = 1'b0;
    o_pc_wen     = 1'b0;
    o_pc_npc     = '0;
    if (!i_rst_n) begin
      case (state)
        RUN: begin
          if (trap) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
            o_flush_exls = 1'b1;
            if (!i_ifu_busy) begin
              o_pc_wen = 1'b1;
              o_pc_npc = trap_tgt;
            end else begin
              next_tgt   = trap_tgt;
              next_state = TRAP_WAIT;
            end
          end else if (br) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
            if (!i_ifu_busy) begin
              o_pc_wen = 1'b1;
              o_pc_npc = i_ex_br_pc;
            end else begin
              next_tgt   = i_ex_br_pc;
              next_state = BR_WAIT;
            end
          end else begin
            // No flush is firing here, so the bubble request passes straight through.
            o_id_hold = load_use;
          end
        end
        BR_WAIT: begin
          o_fetch_hold = 1'b1;
          if (trap) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
            o_flush_exls = 1'b1;
            if (!i_ifu_busy) begin
              o_pc_wen   = 1'b1;
              o_pc_npc   = trap_tgt;
              next_state = RUN;
            end else begin
              next_tgt   = trap_tgt;
              next_state = TRAP_WAIT;
            end
          end else if (!i_ifu_busy) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
            o_pc_wen     = 1'b1;
            o_pc_npc     = r_tgt;
            next_state   = RUN;
          end
        end
        TRAP_WAIT: begin
          o_fetch_hold = 1'b1;
          // Keep younger ops out of MEM for as long as the trap redirect is pending.
          o_flush_exls = 1'b1;
          if (!i_ifu_busy) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
            o_pc_wen     = 1'b1;
            o_pc_npc     = r_tgt;
            next_state   = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state <= RUN;
      r_tgt <= '0;
    end else begin
      state <= next_state;
      r_tgt <= next_tgt;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the five-stage AXI core. Generates the flush and hold controls consumed by the IF/ID, ID/EX and EX/LS pipeline registers, detects load-use hazards, and arbitrates PC redirects between EX-stage branches and MEM-stage traps/mret. Because an AXI fetch cannot be cancelled, a redirect raised while a fetch is in flight is latched and replayed once the fetch completes.

## Interface
- `CPU_WIDTH` (from config.sv), default 64 — datapath/PC width
- `REG_ADDRW` (from config.sv), default 5 — register index width
- i_clk  in  1  core clock
- i_rst_n  in  1  reset; synchronous, active-high (asserted = 1 resets)
- i_id_valid  in  1  ID stage holds a valid instruction
- i_id_rs1 / i_id_rs2  in  REG_ADDRW  ID source indices
- i_id_rs1_ren / i_id_rs2_ren  in  1  source actually read
- i_ex_valid  in  1  EX stage valid
- i_ex_lden  in  1  EX instruction is a load
- i_ex_rdid  in  REG_ADDRW  EX destination
- i_ex_br_en  in  1  EX branch/jump taken (mispredict)
- i_ex_br_pc  in  CPU_WIDTH  branch target
- i_mem_valid  in  1  MEM stage valid
- i_mem_except_en / i_mem_mtime_int / i_mem_mret  in  1  trap sources in MEM
- i_trap_pc  in  CPU_WIDTH  mtvec-derived trap target
- i_mepc  in  CPU_WIDTH  mret target
- i_ifu_busy  in  1  AXI fetch outstanding
- o_flush_ifid / o_flush_idex / o_flush_exls  out  1  register flush pulses
- o_id_hold  out  1  load-use bubble: keep IF/ID, drop ID→EX valid
- o_fetch_hold  out  1  IFU must not issue a new fetch
- o_pc_wen  out  1  PC redirect strobe
- o_pc_npc  out  CPU_WIDTH  redirect target

## Operation
- States: RUN, BR_WAIT, TRAP_WAIT. Latched target `r_tgt`.
- trap = i_mem_valid & (except_en | mtime_int | mret); target = mret ? i_mepc : i_trap_pc. mret and except both set: except wins.
- br = i_ex_valid & i_ex_br_en.
- Load-use (RUN only): o_id_hold = i_id_valid & i_ex_valid & i_ex_lden & i_ex_rdid≠0 & ((rs1_ren & rs1==rdid) | (rs2_ren & rs2==rdid)). Suppressed whenever a flush fires in the same cycle.
- RUN, trap: if !i_ifu_busy → same-cycle o_pc_wen=1, o_npc=target, flush ifid/idex/exls; stay RUN. Else latch target → TRAP_WAIT.
- RUN, br (no trap): if !i_ifu_busy → o_pc_wen, flush ifid/idex; else latch → BR_WAIT.
- BR_WAIT: o_fetch_hold=1. Trap arrives → overwrite r_tgt, → TRAP_WAIT (or redirect immediately with trap flushes if !i_ifu_busy). Else on !i_ifu_busy: o_pc_wen, o_npc=r_tgt, flush ifid/idex → RUN. New br ignored.
- TRAP_WAIT: o_fetch_hold=1, flush_exls held 1 every cycle (younger ops must not reach MEM); on !i_ifu_busy: o_pc_wen, o_npc=r_tgt, flush all three → RUN. Further traps/br ignored.
- Flushes in wait states also assert on entry cycle (ifid/idex for BR, all three for TRAP) to kill wrong-path work.

## Timing
- All decisions combinational from inputs + state; state/r_tgt update at posedge.
- Redirect latency: 0 cycles when IFU idle; otherwise cycle after i_ifu_busy observed low… precisely the first cycle in a wait state with i_ifu_busy=0.
- Load-use: exactly one bubble (load advances to MEM, compare fails next cycle).
- Reset: state=RUN, r_tgt=0; all outputs 0 while i_rst_n=1 regardless of inputs; reset mid-wait discards pending redirect.
- o_pc_wen is a single-cycle pulse per redirect; never two consecutive cycles from the same event.

## Structure
- State enum `pipe_ctrl_state_e` and trap-kind constants go in shared package `cpu_pkg`; widths from config.sv.
- Sub-module `hazard_det`: pure combinational load-use comparator (o_id_hold before suppression).
- Target mux + FSM in top; ~200 lines RTL.

## Test plan
- Load-use: EX lw x5, ID add x6,x5,x1 → o_id_hold=1 one cycle, 0 next; rdid=0 → never held.
- Branch, IFU idle: br_en, br_pc=0x8000_0100 → same-cycle o_pc_wen=1, npc=0x8000_0100, flush_ifid=flush_idex=1, flush_exls=0.
- Branch, IFU busy 3 cycles: BR_WAIT, o_fetch_hold=1 for 3 cycles, then pc_wen with 0x8000_0100 → RUN.
- Trap during BR_WAIT: except_en, trap_pc=0x8000_0000 → TRAP_WAIT, final npc=0x8000_0000, all flushes.
- mret+except together, IFU idle: npc=i_trap_pc, not i_mepc; mret alone → npc=i_mepc.
- Reset asserted in TRAP_WAIT → next cycle RUN, all outputs 0, no pc_wen after release.
